// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes engine: LANES bytes per cycle via internal S-box ROMs.
// Define SUBBYTES_INV_SBOX_EN to build the inverse ROMs and honour in_inv.
module subbytes_iter #(
  parameter int unsigned BYTES = 16,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BYTES-1:0]   in_state,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   out_state,
  output logic                 busy
);

  localparam int unsigned G  = BYTES / LANES;
  localparam int unsigned CW = (G > 1) ? $clog2(G) : 1;

  if (LANES == 0 || (BYTES % LANES) != 0) begin : g_bad_cfg
    $error("subbytes_iter: LANES must divide BYTES");
  end

  // Byte 0x00 occupies the most significant byte of each table.
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_lookup(input logic [7:0] x);
    return FWD_SBOX[8*(255 - int'(x)) +: 8];
  endfunction

`ifdef SUBBYTES_INV_SBOX_EN
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_lookup(input logic [7:0] x);
    return INV_SBOX[8*(255 - int'(x)) +: 8];
  endfunction

  logic mode;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             fsm, fsm_nxt;
  logic [CW-1:0]      cnt;
  logic [8*BYTES-1:0] work;
  logic [8*LANES-1:0] sub;
  logic               ready_q, valid_q, busy_q;
  logic               last_grp;

  assign last_grp = (cnt == CW'(G - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] b;
    assign b = work[8*(32'(cnt)*LANES + l) +: 8];
`ifdef SUBBYTES_INV_SBOX_EN
    assign sub[8*l +: 8] = mode ? inv_lookup(b) : fwd_lookup(b);
`else
    assign sub[8*l +: 8] = fwd_lookup(b);
`endif
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (in_valid && ready_q) fsm_nxt = RUN;
      RUN:     if (last_grp) fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode, so
  // neither in_valid nor out_ready reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      cnt     <= '0;
      work    <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SUBBYTES_INV_SBOX_EN
      mode    <= 1'b0;
`endif
    end else begin
      fsm     <= fsm_nxt;
      ready_q <= (fsm_nxt == IDLE);
      valid_q <= (fsm_nxt == DONE);
      busy_q  <= (fsm_nxt != IDLE);
      case (fsm)
        IDLE: begin
          if (in_valid && ready_q) begin
            work <= in_state;
            cnt  <= '0;
`ifdef SUBBYTES_INV_SBOX_EN
            mode <= in_inv;
`endif
          end
        end
        RUN: begin
          for (int unsigned l = 0; l < LANES; l++)
            work[8*(32'(cnt)*LANES + l) +: 8] <= sub[8*l +: 8];
          if (!last_grp) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign out_state = work;

endmodule

// File: doc/subbytes_iter.md
# subbytes_iter

Iterative, parametrised AES SubBytes engine for the execute stage of the SIMD processor. It accepts a BYTES-wide state over a valid/ready handshake and substitutes LANES bytes per clock through internal S-box ROMs, trading latency for area. It presents the result on a second valid/ready handshake. It replaces the purely combinational 16-way lookup, which relied on an externally supplied S-box array, and adds optional inverse-SubBytes support for decryption.

## Interface
- BYTES, 16, bytes per state word; state width is 8*BYTES.
- LANES, 4, bytes substituted per cycle; must divide BYTES, else elaboration `$error`.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_state/in_inv valid.
- in_ready  out  1  engine can accept; equals (fsm == IDLE).
- in_state  in  8*BYTES  input state; byte i = in_state[8i+7:8i].
- in_inv  in  1  1 = inverse S-box, 0 = forward.
- out_valid  out  1  out_state holds a finished result.
- out_ready  in  1  consumer accepts the result.
- out_state  out  8*BYTES  working/result register, same byte order as in_state.
- busy  out  1  fsm != IDLE.

## Operation
- G = BYTES/LANES groups. A group counter of width max(1, clog2(G)) counts 0..G-1. Group g covers bytes g*LANES .. g*LANES+LANES-1.
- Forward ROM holds the FIPS-197 S-box. Inverse ROM holds the FIPS-197 inverse S-box. Both are 256x8, are internal, and are instantiated LANES times as combinational lookups.
- **IDLE**
  - in_ready=1.
  - On in_valid & in_ready: load in_state into the working register, latch in_inv into mode, clear the counter, go to RUN.
- **RUN**
  - in_ready=0.
  - Each cycle, replace the bytes of group cnt in place with sbox[byte] (inverse if mode=1). All other bytes are held.
  - If cnt == G-1, go to DONE; otherwise cnt++.
  - in_valid is ignored.
- **DONE**
  - out_valid=1; out_state is stable.
  - On out_ready, go to IDLE; out_state keeps its value, out_valid drops.
  - in_valid is ignored (no overlap).
- When G == 1 (LANES == BYTES), RUN lasts exactly one cycle.
- mode and the working register change only on accept and during RUN.

## Timing
- Reset values: in_ready=0 while rst is high, 1 on the first cycle after rst deasserts. out_valid=0, busy=0, out_state=0, cnt=0, mode=0, fsm=IDLE.
- rst has priority over everything. Reset mid-RUN or in DONE discards the operation; no output handshake occurs.
- Latency: input accepted at edge E0. Group g is written at edge E(g+1). out_valid is high after edge EG, i.e. G cycles after accept.
- Result accepted at edge E(G+1). Earliest next accept is at edge E(G+2), giving a throughput of one state per G+2 cycles.
- out_valid stays high and out_state stays stable for any number of cycles of out_ready=0.
- All outputs are registered or decoded directly from fsm; there is no combinational path from in_valid or out_ready to any output.

## Configuration
- `SUBBYTES_INV_SBOX_EN`
  - **Defined:** the inverse ROMs are built; in_inv selects forward or inverse per operation.
  - **Undefined:** the inverse ROMs are omitted; in_inv is ignored, mode is forced to 0, and only forward substitution is performed.

## Test plan
- Forward known-answer, defaults:
  - in_state bytes 0..15 = 0x19,0x3d,0xe3,0xbe,0xa0,0xf4,0xe2,0x2b,0x9a,0xc6,0x8d,0x2a,0xe9,0xf8,0x48,0x08.
  - Expect out bytes = 0xd4,0x27,0x11,0xae,0xe0,0xbf,0x98,0xf1,0xb8,0xb4,0x5d,0xe5,0x1e,0x41,0x52,0x30.
  - Expect out_valid exactly 4 cycles after accept.
- Byte-lane mapping and latency across configurations:
  - Sweep LANES=1,2,16 with all-0x00 input: expect all-0x63.
  - Expect latency of 16, 8 and 1 cycles respectively.
- Inverse (macro defined):
  - in_inv=1, input bytes 0x63,0x7c,0x16,0xed repeated: expect 0x00,0x01,0xff,0x53 repeated.
  - Forward then inverse round trip of a random state returns the original.
- Inverse (macro undefined):
  - in_inv=1, all-0x00 input: expect all-0x63 (forward only).
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE: expect out_valid=1, out_state constant, in_ready=0.
  - Drive in_valid=1 during RUN and DONE: expect it ignored.
  - Release out_ready: expect in_ready=1 on the next cycle.
- Reset mid-operation:
  - Assert rst for 1 cycle at cnt=2: next cycle expect out_valid=0, out_state=0, busy=0.
  - A subsequent operation then completes correctly.
